// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: request/response and external data bus pins of the data-memory access unit
interface dmem_access_unit_if #(parameter int BIT_WIDTH = 32);
  logic req_valid, req_write, req_unsigned;
  logic [1:0] req_size;
  logic [BIT_WIDTH-1:0] req_addr, req_wdata;
  logic stall, rsp_valid, rsp_err;
  logic [BIT_WIDTH-1:0] rsp_rdata;
  logic [BIT_WIDTH-1:0] DAD;
  logic MREQ, WRITE, ACKD_n;
  logic [1:0] SIZE;
  logic [BIT_WIDTH-1:0] ddt_out, ext_ddt;
  logic ddt_oe, ext_oe;
  wire [BIT_WIDTH-1:0] DDT;
  assign DDT = ddt_oe ? ddt_out : ext_oe ? ext_ddt : 'z;
  modport slave (
    input req_valid, req_write, req_unsigned, req_size, req_addr, req_wdata, ACKD_n, DDT,
    output stall, rsp_valid, rsp_err, rsp_rdata, DAD, MREQ, WRITE, SIZE, ddt_out, ddt_oe
  );
  modport master (
    output req_valid, req_write, req_unsigned, req_size, req_addr, req_wdata, ACKD_n, ext_ddt, ext_oe,
    input stall, rsp_valid, rsp_err, rsp_rdata, DAD, MREQ, WRITE, SIZE, ddt_oe, DDT
  );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store bus master with alignment check, timeout and load extension
module dmem_access_unit #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT = 256
) (
  input logic clk,
  input logic rst,
  dmem_access_unit_if.slave bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state_q, state_d;
  logic mreq_q, mreq_d, write_q, write_d, uns_q, uns_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0] size_q, size_d;
  logic [BIT_WIDTH-1:0] dad_q, dad_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic misaligned, expired;
  logic [BIT_WIDTH-1:0] load_ext, store_pat;
  assign misaligned = (bus.req_size == 2'b00 && bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]);
  assign expired = TIMEOUT != 0 && cnt_q + 1'b1 == CW'(TIMEOUT);
  assign load_ext = size_q == 2'b00 ? bus.DDT :
                    size_q == 2'b01 ? {{(BIT_WIDTH-16){~uns_q & bus.DDT[15]}}, bus.DDT[15:0]} :
                                      {{(BIT_WIDTH-8){~uns_q & bus.DDT[7]}}, bus.DDT[7:0]};
  assign store_pat = bus.req_size == 2'b00 ? bus.req_wdata :
                     bus.req_size == 2'b01 ? {{(BIT_WIDTH-16){1'b0}}, bus.req_wdata[15:0]} :
                                             {{(BIT_WIDTH-8){1'b0}}, bus.req_wdata[7:0]};
  assign bus.stall = state_q == BUS || (state_q == IDLE && bus.req_valid);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.DAD = dad_q;
  assign bus.MREQ = mreq_q;
  assign bus.WRITE = write_q;
  assign bus.SIZE = size_q;
  assign bus.ddt_out = wdata_q;
  assign bus.ddt_oe = mreq_q & write_q;
  always_comb begin
    state_d = state_q;
    mreq_d = mreq_q;
    write_d = write_q;
    uns_d = uns_q;
    size_d = size_q;
    dad_d = dad_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (misaligned) begin
          state_d = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d = 1'b1;
        end else begin
          state_d = BUS;
          mreq_d = 1'b1;
          write_d = bus.req_write;
          uns_d = bus.req_unsigned;
          size_d = bus.req_size;
          dad_d = bus.req_addr;
          wdata_d = store_pat;
          cnt_d = '0;
        end
      end
      BUS: if (!bus.ACKD_n) begin
        state_d = RESP;
        mreq_d = 1'b0;
        write_d = 1'b0;
        rsp_valid_d = 1'b1;
        rdata_d = write_q ? '0 : load_ext;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (expired) begin
          state_d = RESP;
          mreq_d = 1'b0;
          write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mreq_q <= 1'b0;
      write_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= 2'b00;
      dad_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mreq_q <= mreq_d;
      write_q <= write_d;
      uns_q <= uns_d;
      size_q <= size_d;
      dad_q <= dad_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed transactions checked every cycle against a spec-level timeline model
module tb_dmem_access_unit;
  localparam int W = 32;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_access_unit_if #(.BIT_WIDTH(W)) bus();
  dmem_access_unit #(.BIT_WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  logic e_mreq, e_write, e_oe, e_rv, e_err, e_stall, e_bus, e_pin, e_pin_err;
  logic [1:0] e_size;
  logic [31:0] e_dad, e_ddt, e_rdata, e_pin_rdata;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", n, $time, a, e);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("MREQ", 32'(bus.MREQ), 32'(e_mreq));
    chk("ddt_oe", 32'(bus.ddt_oe), 32'(e_oe));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
    chk("rsp_rdata", bus.rsp_rdata, e_rdata);
    chk("stall", 32'(bus.stall), 32'(e_stall));
    if (e_bus) begin
      chk("DAD", bus.DAD, e_dad);
      chk("SIZE", 32'(bus.SIZE), 32'(e_size));
      chk("WRITE", 32'(bus.WRITE), 32'(e_write));
    end
    if (e_oe) chk("DDT", bus.DDT, e_ddt);
    if (e_pin) begin
      chk("pin_rdata", bus.rsp_rdata, e_pin_rdata);
      chk("pin_err", 32'(bus.rsp_err), 32'(e_pin_err));
    end
  end
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] sz, input logic uns);
    int nb = sz == 2'b00 ? 32 : sz == 2'b01 ? 16 : 8;
    logic [31:0] m = nb == 32 ? 32'hFFFF_FFFF : (32'h1 << nb) - 32'h1;
    logic [31:0] v = d & m;
    if (!uns && nb < 32 && d[nb-1]) v = v | ~m;
    return v;
  endfunction
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_idle(input logic st);
    e_mreq = 0; e_oe = 0; e_rv = 0; e_err = 0; e_rdata = 0; e_stall = st; e_bus = 0; e_pin = 0;
  endtask
  task automatic run(input logic w, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] bd, input int lat,
                     input logic [31:0] pin_rdata, input logic pin_err);
    logic mis = (sz == 2'b00 && addr[1:0] != 2'b00) || (sz == 2'b01 && addr[0]);
    logic [31:0] pat = sz == 2'b00 ? wd : sz == 2'b01 ? (wd & 32'hFFFF) : (wd & 32'hFF);
    int n = lat == 0 ? TO : lat;
    bus.req_valid = 1; bus.req_write = w; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.ACKD_n = 1; bus.ext_oe = 0;
    expect_idle(1);
    next_cycle;
    bus.req_valid = 0;
    if (!mis) for (int k = 0; k < n; k++) begin
      e_mreq = 1; e_bus = 1; e_write = w; e_size = sz; e_dad = addr; e_oe = w; e_ddt = pat;
      e_rv = 0; e_err = 0; e_rdata = 0; e_stall = 1;
      if (lat != 0 && k == lat - 1) begin
        bus.ACKD_n = 0; bus.ext_oe = !w; bus.ext_ddt = bd;
      end
      next_cycle;
      bus.ACKD_n = 1; bus.ext_oe = 0;
    end
    e_mreq = 0; e_bus = 0; e_oe = 0; e_rv = 1; e_err = mis || lat == 0;
    e_rdata = (e_err || w) ? 32'h0 : ext(bd, sz, uns);
    e_stall = 0; e_pin = 1; e_pin_rdata = pin_rdata; e_pin_err = pin_err;
    next_cycle;
    expect_idle(0);
    next_cycle;
  endtask
  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.ACKD_n = 1; bus.ext_oe = 0; bus.ext_ddt = 0;
    expect_idle(0);
    next_cycle;
    next_cycle;
    e_bus = 1; e_dad = 0; e_size = 0; e_write = 0;
    chk_en = 1;
    next_cycle;
    rst = 0;
    expect_idle(0);
    next_cycle;
    run(0, 2'b00, 0, 32'h0800_0010, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0);
    run(0, 2'b10, 0, 32'h0800_0005, 32'h0, 32'h1234_5680, 2, 32'hFFFF_FF80, 0);
    run(0, 2'b10, 1, 32'h0800_0006, 32'h0, 32'h1234_5680, 2, 32'h0000_0080, 0);
    run(0, 2'b01, 0, 32'h0800_0012, 32'h0, 32'hABCD_8001, 1, 32'hFFFF_8001, 0);
    run(0, 2'b11, 0, 32'h0800_0007, 32'h0, 32'h0000_00FE, 1, 32'hFFFF_FFFE, 0);
    run(1, 2'b10, 0, 32'hF000_0000, 32'hFFFF_FF41, 32'h0, 2, 32'h0, 0);
    run(1, 2'b01, 0, 32'h0800_0002, 32'h1234_ABCD, 32'h0, 1, 32'h0, 0);
    run(1, 2'b00, 0, 32'h0800_0040, 32'h8765_4321, 32'h0, 3, 32'h0, 0);
    run(0, 2'b01, 0, 32'h0800_0003, 32'h0, 32'h0, 1, 32'h0, 1);
    run(0, 2'b00, 0, 32'h0800_0002, 32'h0, 32'h0, 1, 32'h0, 1);
    run(0, 2'b00, 0, 32'h0800_0020, 32'h0, 32'h0, 0, 32'h0, 1);
    run(0, 2'b00, 0, 32'h0800_0024, 32'h0, 32'hCAFE_F00D, TO, 32'hCAFE_F00D, 0);
    bus.req_valid = 1; bus.req_write = 1; bus.req_size = 2'b00; bus.req_unsigned = 0;
    bus.req_addr = 32'h0800_0030; bus.req_wdata = 32'h5555_AAAA; bus.ACKD_n = 1;
    expect_idle(1);
    next_cycle;
    bus.req_valid = 0;
    e_mreq = 1; e_bus = 1; e_write = 1; e_size = 2'b00; e_dad = 32'h0800_0030;
    e_oe = 1; e_ddt = 32'h5555_AAAA; e_stall = 1;
    next_cycle;
    rst = 1;
    next_cycle;
    rst = 0;
    expect_idle(0);
    e_bus = 1; e_dad = 0; e_size = 0; e_write = 0;
    next_cycle;
    expect_idle(0);
    next_cycle;
    run(0, 2'b00, 0, 32'h0800_0010, 32'h0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
